addsub_arbiter: RTL and testbench

Scheduler that shares one external 8-bit combinational add/sub unit between two requesters.
- Arbitrates round-robin between the two requesters.
- Registers the winner's operands and op onto the unit's inputs, then captures the unit's result and carry one cycle later.
- Returns the result with a per-requester done pulse.
- Sits between two client datapaths and the single shared add/sub instance.

---
 rtl/addsub_arbiter.sv | 74 +++++++
 tb/tb_addsub_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin scheduler sharing one external add/sub unit between two requesters
module addsub_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_req,
    input  logic [WIDTH-1:0] r0_x,
    input  logic [WIDTH-1:0] r0_y,
    input  logic             r0_sub,
    output logic             r0_gnt,
    output logic             r0_done,
    input  logic             r1_req,
    input  logic [WIDTH-1:0] r1_x,
    input  logic [WIDTH-1:0] r1_y,
    input  logic             r1_sub,
    output logic             r1_gnt,
    output logic             r1_done,
    output logic [WIDTH-1:0] au_x,
    output logic [WIDTH-1:0] au_y,
    output logic             au_select,
    input  logic [WIDTH-1:0] au_ans,
    input  logic             au_cout,
    output logic [WIDTH-1:0] res,
    output logic             res_cout,
    output logic             res_ovf,
    output logic             busy
);
    typedef enum logic {IDLE, ISSUE} state_t;
    state_t state, state_n;
    logic   last_grant, pick1, any_req, ovf;
    always_comb begin
        any_req = r0_req || r1_req;
        pick1   = r1_req && (!r0_req || !last_grant);
        state_n = (state == IDLE && any_req) ? ISSUE : IDLE;
        ovf     = (au_x[WIDTH-1] == (au_y[WIDTH-1] ^ au_select)) && (au_ans[WIDTH-1] != au_x[WIDTH-1]);
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            au_x       <= '0;
            au_y       <= '0;
            au_select  <= 1'b0;
            res        <= '0;
            res_cout   <= 1'b0;
            res_ovf    <= 1'b0;
            last_grant <= 1'b1;
            r0_done    <= 1'b0;
            r1_done    <= 1'b0;
        end else begin
            r0_done <= 1'b0;
            r1_done <= 1'b0;
            if (state == IDLE && any_req) begin
                au_x       <= pick1 ? r1_x : r0_x;
                au_y       <= pick1 ? r1_y : r0_y;
                au_select  <= pick1 ? r1_sub : r0_sub;
                last_grant <= pick1;
            end
            if (state == ISSUE) begin
                res      <= au_ans;
                res_cout <= au_cout;
                res_ovf  <= ovf;
                r0_done  <= !last_grant;
                r1_done  <= last_grant;
            end
        end
    end
    assign busy   = (state == ISSUE);
    assign r0_gnt = busy && !last_grant;
    assign r1_gnt = busy && last_grant;
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: random and directed checks of addsub_arbiter against a transaction-level model
module tb_addsub_arbiter;
    logic       clk = 1'b0, rst = 1'b1;
    logic       r0_req = 1'b0, r1_req = 1'b0, r0_sub = 1'b0, r1_sub = 1'b0;
    logic [7:0] r0_x = '0, r0_y = '0, r1_x = '0, r1_y = '0;
    logic       r0_gnt, r0_done, r1_gnt, r1_done, au_select, au_cout, res_cout, res_ovf, busy;
    logic [7:0] au_x, au_y, au_ans, res;

    addsub_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_x(r0_x), .r0_y(r0_y), .r0_sub(r0_sub), .r0_gnt(r0_gnt), .r0_done(r0_done),
        .r1_req(r1_req), .r1_x(r1_x), .r1_y(r1_y), .r1_sub(r1_sub), .r1_gnt(r1_gnt), .r1_done(r1_done),
        .au_x(au_x), .au_y(au_y), .au_select(au_select), .au_ans(au_ans), .au_cout(au_cout),
        .res(res), .res_cout(res_cout), .res_ovf(res_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    // The shared unit: subtract is x + ~y + 1, so carry means "no borrow".
    assign {au_cout, au_ans} = au_select ? ({1'b0, au_x} + {1'b0, ~au_y} + 9'd1) : ({1'b0, au_x} + {1'b0, au_y});

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [8:0] act, input int exp);
        n_cmp++;
        if (act !== 9'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, 9'(exp), $time);
        end
    endtask

    // Transaction-level model: one operation at a time, result from plain integer arithmetic.
    bit started = 0, m_busy = 0, m_last = 1, m_own = 0, m_sub = 0;
    int m_x, m_y, full, sx, sy, sr;
    int e_g0 = 0, e_g1 = 0, e_d0 = 0, e_d1 = 0, e_busy = 0;
    int e_ax = 0, e_ay = 0, e_sel = 0, e_res = 0, e_cout = 0, e_ovf = 0;

    initial forever begin
        @(posedge clk);
        e_g0 = 0; e_g1 = 0; e_d0 = 0; e_d1 = 0;
        if (rst) begin
            started = 1; m_busy = 0; m_last = 1; e_busy = 0;
            e_ax = 0; e_ay = 0; e_sel = 0; e_res = 0; e_cout = 0; e_ovf = 0;
        end else if (m_busy) begin
            full   = m_sub ? m_x + (255 - m_y) + 1 : m_x + m_y;
            e_res  = full % 256;
            e_cout = (full >= 256) ? 1 : 0;
            sx     = (m_x >= 128) ? m_x - 256 : m_x;
            sy     = (m_y >= 128) ? m_y - 256 : m_y;
            sr     = m_sub ? sx - sy : sx + sy;
            e_ovf  = (sr > 127 || sr < -128) ? 1 : 0;
            e_d0   = m_own ? 0 : 1;
            e_d1   = m_own ? 1 : 0;
            m_busy = 0; e_busy = 0;
        end else if (r0_req || r1_req) begin
            m_own  = (r0_req && r1_req) ? !m_last : r1_req;
            m_x    = m_own ? int'(r1_x) : int'(r0_x);
            m_y    = m_own ? int'(r1_y) : int'(r0_y);
            m_sub  = m_own ? r1_sub : r0_sub;
            m_last = m_own; m_busy = 1; e_busy = 1;
            e_ax = m_x; e_ay = m_y; e_sel = m_sub ? 1 : 0;
            e_g0 = m_own ? 0 : 1;
            e_g1 = m_own ? 1 : 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("r0_gnt", 9'(r0_gnt), e_g0);
            chk("r1_gnt", 9'(r1_gnt), e_g1);
            chk("r0_done", 9'(r0_done), e_d0);
            chk("r1_done", 9'(r1_done), e_d1);
            chk("busy", 9'(busy), e_busy);
            chk("au_x", 9'(au_x), e_ax);
            chk("au_y", 9'(au_y), e_ay);
            chk("au_select", 9'(au_select), e_sel);
            chk("res", 9'(res), e_res);
            chk("res_cout", 9'(res_cout), e_cout);
            chk("res_ovf", 9'(res_ovf), e_ovf);
        end
    end

    task automatic drive(input int who, input int rq, input int x, input int y, input int sub);
        if (who != 0) begin
            r1_req = (rq != 0); r1_x = 8'(x); r1_y = 8'(y); r1_sub = (sub != 0);
        end else begin
            r0_req = (rq != 0); r0_x = 8'(x); r0_y = 8'(y); r0_sub = (sub != 0);
        end
    endtask

    task automatic scramble(input int who);
        drive(who, 0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
    endtask

    // Lone request from idle: gnt on the first cycle after sampling, done on the next.
    task automatic op(input string nm, input int who, input int x, input int y, input int sub,
                      input int er, input int ec, input int eo);
        int lat;
        lat = -1;
        drive(who, 1, x, y, sub);
        for (int i = 0; i < 8 && lat < 0; i++) begin
            @(negedge clk);
            if (who != 0 ? r1_gnt : r0_gnt) lat = i;
        end
        chk({nm, "_gnt_latency"}, 9'(lat), 0);
        scramble(who);
        @(negedge clk);
        chk({nm, "_done"}, 9'(who != 0 ? r1_done : r0_done), 1);
        chk({nm, "_res"}, 9'(res), er);
        chk({nm, "_cout"}, 9'(res_cout), ec);
        chk({nm, "_ovf"}, 9'(res_ovf), eo);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", 9'(busy), 0);
        chk("rst_res", 9'(res), 0);
        chk("rst_au_x", 9'(au_x), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        op("add", 0, 'h0E, 'h07, 0, 'h15, 0, 0);
        op("sub_borrow", 1, 'h02, 'h03, 1, 'hFF, 0, 0);
        op("sub_noborrow", 1, 'h76, 'h56, 1, 'h20, 1, 0);
        op("ovf", 0, 'h7F, 'h01, 0, 'h80, 0, 1);
        op("wrap", 0, 'hFF, 'h01, 0, 'h00, 1, 0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1, 'h28, 'h09, 0);
        drive(1, 1, 'hA8, 'h09, 1);
        @(negedge clk);
        chk("cont_first_r0", {7'b0, r0_gnt, r1_gnt}, 2);
        scramble(0);
        @(negedge clk);
        chk("cont_r0_done", 9'(r0_done), 1);
        chk("cont_r0_res", 9'(res), 'h31);
        @(negedge clk);
        chk("cont_r1_gnt", 9'(r1_gnt), 1);
        scramble(1);
        @(negedge clk);
        chk("cont_r1_done", 9'(r1_done), 1);
        chk("cont_r1_res", 9'(res), 'h9F);
        chk("cont_r1_cout", 9'(res_cout), 1);

        drive(0, 1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
        drive(1, 1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("alt_r0_gnt", 9'(r0_gnt), (k % 4 == 0) ? 1 : 0);
            chk("alt_r1_gnt", 9'(r1_gnt), (k % 4 == 2) ? 1 : 0);
        end
        scramble(0);
        scramble(1);

        drive(0, 1, 'h33, 'h44, 0);
        @(negedge clk);
        chk("abort_gnt", 9'(r0_gnt), 1);
        rst = 1'b1;
        scramble(0);
        @(negedge clk);
        chk("abort_no_done", {7'b0, r0_done, r1_done}, 0);
        chk("abort_res", 9'(res), 0);
        chk("abort_busy", 9'(busy), 0);
        rst = 1'b0;
        op("after_abort", 1, 'h12, 'h34, 0, 'h46, 0, 0);

        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (r0_gnt) scramble(0);
            else if (!r0_req && $urandom_range(0, 1) == 1)
                drive(0, 1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
            if (r1_gnt) scramble(1);
            else if (!r1_req && $urandom_range(0, 1) == 1)
                drive(1, 1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
            rst = ($urandom_range(0, 49) == 0);
        end
        rst = 1'b0;
        scramble(0);
        scramble(1);
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
